// File: rtl/ultrasonic_poll_filter.sv
// Polls an ultrasonic sensor stage, smooths returned distances over a sliding window and derives a debounced presence flag.
// Optional build macro: US_TIMEOUT_STATS_EN adds an 8-bit saturating timeout counter output.
module ultrasonic_poll_filter #(
  parameter int DIST_W         = 16,
  parameter int POLL_CYCLES    = 3_000_000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int MAX_CM         = 400,
  parameter int AVG_LOG2       = 2,
  parameter int NEAR_CM        = 20,
  parameter int FAR_CM         = 30,
  parameter int HOLD           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              trigger,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  output logic [DIST_W-1:0] dist_avg,
  output logic              avg_valid,
  output logic              presence,
  output logic              presence_chg
`ifdef US_TIMEOUT_STATS_EN
  ,
  output logic [7:0]        timeout_cnt
`endif
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = DIST_W + AVG_LOG2;
  localparam int CW = $clog2(POLL_CYCLES + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam int FW = AVG_LOG2 + 1;

  localparam logic [CW-1:0]     POLL_LAST = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0]     TMO_CNT   = CW'(TIMEOUT_CYCLES);
  localparam logic [DIST_W-1:0] MAX_D     = DIST_W'(MAX_CM);
  localparam logic [DIST_W-1:0] NEAR_D    = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] FAR_D     = DIST_W'(FAR_CM);
  localparam logic [HW-1:0]     HOLD_M1   = HW'(HOLD - 1);
  localparam logic [FW-1:0]     FILL_FULL = FW'(N);
  localparam logic [FW-1:0]     FILL_M1   = FW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_poll_cnt;
  logic                w_smp_vld;
  logic [DIST_W-1:0]   w_smp_dat;
  logic                w_timeout;

  logic [DIST_W-1:0]   r_win [N];
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [FW-1:0]       r_fill;
  logic [SW-1:0]       r_sum;
  logic [SW-1:0]       w_new_sum;
  logic [DIST_W-1:0]   w_oldest;
  logic                w_full_nxt;

  logic [HW-1:0]       r_near_cnt;
  logic [HW-1:0]       r_far_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A real sample in the timeout cycle takes priority over substitution.
  always_comb begin
    w_state_nxt = r_state;
    w_smp_vld   = 1'b0;
    w_smp_dat   = '0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (dist_valid) begin
          w_smp_vld   = 1'b1;
          w_smp_dat   = (dist_in > MAX_D) ? MAX_D : dist_in;
          w_state_nxt = S_GAP;
        end else if (r_poll_cnt == TMO_CNT) begin
          w_smp_vld   = 1'b1;
          w_smp_dat   = MAX_D;
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_poll_cnt >= POLL_LAST) begin
          w_state_nxt = S_TRIG;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign trigger = (r_state == S_TRIG);

  // Counter holds the number of cycles elapsed since the trigger cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
    end else if (r_state == S_TRIG) begin
      r_poll_cnt <= CW'(1);
    end else if (r_state != S_IDLE) begin
      r_poll_cnt <= r_poll_cnt + CW'(1);
    end
  end

  assign w_oldest   = r_win[r_wr_ptr];
  assign w_new_sum  = r_sum + SW'(w_smp_dat) - SW'(w_oldest);
  assign w_full_nxt = (r_fill >= FILL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_sum     <= '0;
      dist_avg  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (w_smp_vld) begin
        r_win[r_wr_ptr] <= w_smp_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_sum           <= w_new_sum;
        if (r_fill != FILL_FULL) r_fill <= r_fill + FW'(1);
        if (w_full_nxt) begin
          dist_avg  <= w_new_sum[SW-1:AVG_LOG2];
          avg_valid <= 1'b1;
        end
      end
    end
  end

  // Averages inside the hysteresis band reset both debounce counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presence     <= 1'b0;
      presence_chg <= 1'b0;
      r_near_cnt   <= '0;
      r_far_cnt    <= '0;
    end else begin
      presence_chg <= 1'b0;
      if (avg_valid) begin
        if (!presence) begin
          r_far_cnt <= '0;
          if (dist_avg <= NEAR_D) begin
            if (r_near_cnt == HOLD_M1) begin
              presence     <= 1'b1;
              presence_chg <= 1'b1;
              r_near_cnt   <= '0;
            end else begin
              r_near_cnt <= r_near_cnt + HW'(1);
            end
          end else begin
            r_near_cnt <= '0;
          end
        end else begin
          r_near_cnt <= '0;
          if (dist_avg >= FAR_D) begin
            if (r_far_cnt == HOLD_M1) begin
              presence     <= 1'b0;
              presence_chg <= 1'b1;
              r_far_cnt    <= '0;
            end else begin
              r_far_cnt <= r_far_cnt + HW'(1);
            end
          end else begin
            r_far_cnt <= '0;
          end
        end
      end
    end
  end

`ifdef US_TIMEOUT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
    end else if (w_timeout && (timeout_cnt != 8'hFF)) begin
      timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ultrasonic_poll_filter.sv
// Scoreboard bench for ultrasonic_poll_filter with short poll/timeout periods.
module tb_ultrasonic_poll_filter;
  localparam int POLL = 100;
  localparam int TMO  = 60;
  localparam int MAXC = 400;
  localparam int NEAR = 20;
  localparam int FAR  = 30;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger;
  logic [15:0] dist_in = '0;
  logic        dist_valid = 1'b0;
  logic [15:0] dist_avg;
  logic        avg_valid;
  logic        presence;
  logic        presence_chg;
`ifdef US_TIMEOUT_STATS_EN
  logic [7:0]  timeout_cnt;
`endif

  ultrasonic_poll_filter #(
    .DIST_W(16), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .MAX_CM(MAXC),
    .AVG_LOG2(2), .NEAR_CM(NEAR), .FAR_CM(FAR), .HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
    .dist_in(dist_in), .dist_valid(dist_valid), .dist_avg(dist_avg),
    .avg_valid(avg_valid), .presence(presence), .presence_chg(presence_chg)
`ifdef US_TIMEOUT_STATS_EN
    , .timeout_cnt(timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    bit pres;
    bit chg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   av_cnt = 0;
  int   last_av_cyc = -1;
  bit   pend = 0;
  bit   pend_pres, pend_chg;

  int   m_win[4];
  int   m_wp, m_fill, m_near, m_far;
  bit   m_pres;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (presence !== pend_pres || presence_chg !== pend_chg) begin
        errors++;
        $display("FAIL presence: got pres=%0b chg=%0b expected pres=%0b chg=%0b", presence, presence_chg, pend_pres, pend_chg);
      end
      pend = 0;
    end else if (presence_chg === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL spurious_presence_chg: got 1 expected 0 at cycle %0d", cyc);
    end
    if (avg_valid === 1'b1) begin
      av_cnt++;
      last_av_cyc = cyc;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_avg_valid: got dist_avg=%0d with no expected sample", dist_avg);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (dist_avg !== 16'(e.avg)) begin
          errors++;
          $display("FAIL dist_avg: got %0d expected %0d", dist_avg, e.avg);
        end
        pend = 1;
        pend_pres = e.pres;
        pend_chg = e.chg;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_win[i] = 0;
    m_wp = 0; m_fill = 0; m_near = 0; m_far = 0; m_pres = 0;
    q.delete();
    pend = 0;
  endtask

  task automatic model_accept(input int v);
    exp_t e;
    int   s;
    m_win[m_wp] = v;
    m_wp = (m_wp + 1) % 4;
    if (m_fill < 4) m_fill++;
    if (m_fill == 4) begin
      s = m_win[0] + m_win[1] + m_win[2] + m_win[3];
      e.avg = s / 4;
      e.chg = 0;
      if (!m_pres) begin
        m_far = 0;
        if (e.avg <= NEAR) m_near++; else m_near = 0;
      end else begin
        m_near = 0;
        if (e.avg >= FAR) m_far++; else m_far = 0;
      end
      if (m_near == HOLD || m_far == HOLD) begin
        m_pres = !m_pres;
        m_near = 0;
        m_far = 0;
        e.chg = 1;
      end
      e.pres = m_pres;
      q.push_back(e);
    end
  endtask

  task automatic wait_trigger(output int tc);
    bit found = 0;
    tc = -1;
    for (int i = 0; i < 3 * POLL && !found; i++) begin
      @(negedge clk);
      if (trigger === 1'b1) begin
        found = 1;
        tc = cyc;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL trigger_timeout: got no trigger expected one within %0d cycles", 3 * POLL);
    end
  endtask

  // One poll: drv=1 drives a sample dly cycles after trigger; drv=0 lets it time out.
  task automatic poll(input bit drv, input int dly, input int val, input bit gap_drive, output int tc);
    int last;
    wait_trigger(tc);
    if (!drv) model_accept(MAXC);
    last = drv ? dly + 2 : TMO + 2;
    if (last < 32) last = 32;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (trigger !== 1'b0) begin
          errors++;
          $display("FAIL trigger_width: got %0b expected 0 one cycle after pulse", trigger);
        end
      end
      if (drv && k == dly) begin
        dist_in = 16'(val);
        dist_valid = 1'b1;
        model_accept(val > MAXC ? MAXC : val);
      end
      if (gap_drive && k == 30) begin
        dist_in = 16'd5;
        dist_valid = 1'b1;
      end
      if ((drv && k == dly + 1) || (gap_drive && k == 31)) dist_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (trigger !== 0 || avg_valid !== 0 || dist_avg !== 0 || presence !== 0 || presence_chg !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got trig=%0b av=%0b avg=%0d pres=%0b chg=%0b expected all 0",
               trigger, avg_valid, dist_avg, presence, presence_chg);
    end
`ifdef US_TIMEOUT_STATS_EN
    checks++;
    if (timeout_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_timeout_cnt: got %0d expected 0", timeout_cnt);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_fill_and_period();
    int t[4];
    int av0;
    av0 = av_cnt;
    for (int i = 0; i < 3; i++) poll(1, 10, 50, 0, t[i]);
    checks++;
    if (av_cnt !== av0) begin
      errors++;
      $display("FAIL early_avg_valid: got %0d pulses expected 0 before window full", av_cnt - av0);
    end
    poll(1, 10, 50, 0, t[3]);
    checks++;
    if (last_av_cyc !== t[3] + 11) begin
      errors++;
      $display("FAIL avg_latency: got cycle %0d expected %0d", last_av_cyc, t[3] + 11);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (t[i] - t[i-1] !== POLL) begin
        errors++;
        $display("FAIL trigger_period: got %0d expected %0d", t[i] - t[i-1], POLL);
      end
    end
  endtask

  task automatic test_presence_set();
    int tc;
    for (int i = 0; i < 4; i++) poll(1, 10, 10, 0, tc);
    @(negedge clk);
    checks++;
    if (presence !== 1'b1) begin
      errors++;
      $display("FAIL presence_set: got %0b expected 1", presence);
    end
  endtask

  task automatic test_timeout();
    int t0, t1;
    poll(0, 0, 0, 0, t0);
    checks++;
    if (last_av_cyc !== t0 + TMO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got cycle %0d expected %0d", last_av_cyc, t0 + TMO + 1);
    end
`ifdef US_TIMEOUT_STATS_EN
    checks++;
    if (timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL timeout_cnt: got %0d expected 1", timeout_cnt);
    end
`endif
    poll(1, TMO, 15, 0, t1);
    checks++;
    if (t1 - t0 !== POLL) begin
      errors++;
      $display("FAIL timeout_period: got %0d expected %0d", t1 - t0, POLL);
    end
  endtask

  task automatic test_clamp_and_gap();
    int tc;
    poll(1, 10, 900, 1, tc);
    poll(1, 12, 33, 1, tc);
  endtask

  task automatic test_enable_low();
    int tc, av0;
    av0 = av_cnt;
    wait_trigger(tc);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    dist_in = 16'd7;
    dist_valid = 1'b1;
    @(negedge clk);
    dist_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (av_cnt !== av0 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL enable_low: got %0d pulses trig=%0b expected 0 pulses trig=0", av_cnt - av0, trigger);
    end
    enable = 1'b1;
    poll(1, 10, 80, 0, tc);
  endtask

  task automatic test_reset_mid_wait();
    int tc, av0;
    wait_trigger(tc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (trigger !== 0 || dist_avg !== 0 || presence !== 0 || avg_valid !== 0) begin
      errors++;
      $display("FAIL reset_mid_wait: got trig=%0b avg=%0d pres=%0b av=%0b expected all 0",
               trigger, dist_avg, presence, avg_valid);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    av0 = av_cnt;
    for (int i = 0; i < 3; i++) poll(1, 10, 20, 0, tc);
    checks++;
    if (av_cnt !== av0) begin
      errors++;
      $display("FAIL refill_after_reset: got %0d pulses expected 0", av_cnt - av0);
    end
    poll(1, 10, 20, 0, tc);
    checks++;
    if (av_cnt !== av0 + 1) begin
      errors++;
      $display("FAIL refill_first_avg: got %0d pulses expected 1", av_cnt - av0);
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_period();
    test_presence_set();
    test_timeout();
    test_clamp_and_gap();
    test_enable_low();
    test_reset_mid_wait();
    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
